// File: rtl/sha256_w_sched_stage_param_if.sv
// Handshake and data bundle for one elastic SHA-256 message-schedule stage.
// The master drives the input window and the downstream ready; the slave is the stage.
interface sha256_w_sched_stage_param_if #(
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [511:0]     in_window;
  logic [6:0]       in_round;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [511:0]     out_window;
  logic [6:0]       out_round;
  logic [TAG_W-1:0] out_tag;
  logic             out_last;
  logic             err;

  modport master (
    output in_valid, in_window, in_round, in_tag, out_ready,
    input  in_ready, out_valid, out_window, out_round, out_tag, out_last, err
  );

  modport slave (
    input  in_valid, in_window, in_round, in_tag, out_ready,
    output in_ready, out_valid, out_window, out_round, out_tag, out_last, err
  );
endinterface

// File: rtl/sha256_w_sched_stage_param.sv
// Elastic SHA-256 schedule stage: expands NEW_WORDS words from a 16-word window in one
// combinational chain and presents the shifted window through a single output register.
module sha256_w_sched_stage_param #(
  parameter int          NEW_WORDS = 2,
  parameter int          TAG_W     = 8,
  parameter int          FIXED_W15 = 0,
  parameter logic [31:0] W15_CONST = 32'h00000100
) (
  input  logic                            CLK,
  input  logic                            RST,
  sha256_w_sched_stage_param_if.slave     bus
);

  generate
    if (NEW_WORDS < 1 || NEW_WORDS > 4) begin : g_bad_new_words
      $error("sha256_w_sched_stage_param: NEW_WORDS must be 1..4");
    end
  endgenerate

  localparam logic [6:0] ROUND_MIN = 7'd16;
  localparam logic [6:0] ROUND_MAX = 7'(64 - NEW_WORDS);

  function automatic logic [31:0] f_sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] f_sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  logic [31:0]      w_ext [0:15+NEW_WORDS];
  logic [511:0]     w_next_window;
  logic             w_sub_w15;
  logic [6:0]       w_round_next;
  logic             w_last;
  logic             w_illegal;
  logic             w_accept;

  logic             r_out_valid;
  logic [511:0]     r_out_window;
  logic [6:0]       r_out_round;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_last;
  logic             r_err;

  assign w_sub_w15    = (FIXED_W15 != 0) && (bus.in_round == 7'd16);
  assign w_round_next = bus.in_round + 7'(NEW_WORDS);
  assign w_last       = (w_round_next == 7'd64);
  assign w_illegal    = (bus.in_round < ROUND_MIN) || (bus.in_round > ROUND_MAX);
  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Word expansion: later words may depend on words produced earlier in the same chain.
  always_comb begin
    for (int i = 0; i < 16 + NEW_WORDS; i++) begin
      w_ext[i] = 32'h0000_0000;
    end
    for (int i = 0; i < 16; i++) begin
      w_ext[i] = bus.in_window[511-32*i -: 32];
    end
    w_ext[15] = w_sub_w15 ? W15_CONST : bus.in_window[31:0];
    for (int k = 0; k < NEW_WORDS; k++) begin
      w_ext[16+k] = f_sig1(w_ext[14+k]) + w_ext[9+k] + f_sig0(w_ext[1+k]) + w_ext[k];
    end
    w_next_window = 512'h0;
    for (int i = 0; i < 16; i++) begin
      w_next_window[511-32*i -: 32] = w_ext[i+NEW_WORDS];
    end
  end

  // Output register; data only changes on accept so it is stable under backpressure.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out_valid  <= 1'b0;
      r_out_window <= 512'h0;
      r_out_round  <= 7'd0;
      r_out_tag    <= '0;
      r_out_last   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_out_window <= w_next_window;
        r_out_round  <= w_round_next;
        r_out_tag    <= bus.in_tag;
        r_out_last   <= w_last;
        if (w_illegal) begin
          r_err <= 1'b1;
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_window = r_out_window;
  assign bus.out_round  = r_out_round;
  assign bus.out_tag    = r_out_tag;
  assign bus.out_last   = r_out_last;
  assign bus.err        = r_err;

endmodule
